// File: rtl/m31_add_arbiter.sv
// Purpose: round-robin arbiter that shares one Mersenne-31 adder among NUM_REQ requesters.
// Latency: 1 cycle from request acceptance to rsp_valid_o; one operation per cycle when drained.
// Backpressure: a held result (rsp_valid_o=1, rsp_ready_i=0) blocks every grant; drain and fire overlap.
module m31_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*31-1:0]  req_a_i,
    input  logic [NUM_REQ*31-1:0]  req_b_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [30:0]            rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [15:0]            op_cnt_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            rsp_valid_q;
    logic [30:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q;
    logic [15:0]     op_cnt_q;

    logic            slot_free;
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic            fire;
    logic [30:0]     a_sel, b_sel;
    logic [31:0]     sum_raw;
    logic [30:0]     sum_fold;

    // The output register can take a new result if empty or being drained this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready_i;

    // Cyclic priority search starting at ptr_q; walking downward lets the closest requester win.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    // Reset gates acceptance so nothing is taken while the block is held in reset.
    assign fire = grant_vld && slot_free && rst_n;

    // One-hot ready to the granted requester and operand mux for the adder.
    always_comb begin
        req_ready_o = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                req_ready_o[k] = fire;
                a_sel          = req_a_i[k*31 +: 31];
                b_sel          = req_b_i[k*31 +: 31];
            end
        end
    end

    // End-around-carry addition; the all-ones pattern is the second encoding of zero, so fold it.
    always_comb begin
        sum_raw    = {1'b0, a_sel} + {1'b0, b_sel};
        sum_fold   = sum_raw[30:0] + {30'd0, sum_raw[31]};
        rsp_data_d = (sum_fold == 31'h7FFF_FFFF) ? 31'd0 : sum_fold;
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        if (grant_id == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_id + 1'b1;
        end
    end

    // Result register, round-robin pointer and operation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
            op_cnt_q    <= '0;
        end else if (fire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= grant_id;
            ptr_q       <= ptr_d;
            op_cnt_q    <= op_cnt_q + 16'd1;
        end else if (rsp_ready_i) begin
            // Drained with nothing new: data and id keep their last values.
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_m31_add_arbiter.sv
// Purpose: directed self-checking bench for m31_add_arbiter with NUM_REQ=4.
// Latency: checks rsp outputs 1 ns after the edge following each fire.
// Backpressure: exercises held results, overlapped drain/fire and reset mid-operation.
module tb_m31_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*31-1:0] req_a_i;
    logic [NUM_REQ*31-1:0] req_b_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [30:0]           rsp_data_o;
    logic [ID_W-1:0]       rsp_id_o;
    logic [15:0]           op_cnt_o;

    int checks;
    int errors;

    m31_add_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .op_cnt_o    (op_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [30:0] a, input logic [30:0] b);
        req_a_i[k*31 +: 31] = a;
        req_b_i[k*31 +: 31] = b;
    endtask

    // Checks the whole response side against hand-computed values.
    task automatic chk_rsp(input string tag, input logic v, input logic [30:0] d,
                           input logic [1:0] id, input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(rsp_valid_o), 32'(v));
        chk({tag, ".data"},  32'(rsp_data_o),  32'(d));
        chk({tag, ".id"},    32'(rsp_id_o),    32'(id));
        chk({tag, ".cnt"},   32'(op_cnt_o),    32'(cnt));
    endtask

    logic [30:0] va [4];
    logic [30:0] vb [4];
    logic [30:0] vr [4];
    logic [1:0]  rr_id [6];
    logic [30:0] rr_dat [4];

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        req_valid_i = 4'hF;
        rsp_ready_i = 1'b1;
        req_a_i     = '0;
        req_b_i     = '0;

        // Reset: state cleared and no acceptance even with every requester asking.
        step();
        step();
        chk_rsp("reset", 1'b0, 31'd0, 2'd0, 16'd0);
        chk("reset.ready", 32'(req_ready_o), 32'h0);

        // Requester 0 alone: 0x7FFFFFFE + 1 folds to 0.
        rst_n       = 1'b1;
        req_valid_i = 4'b0001;
        set_op(0, 31'h7FFF_FFFE, 31'h0000_0001);
        #1;
        chk("single.ready", 32'(req_ready_o), 32'h1);
        step();
        chk_rsp("single", 1'b1, 31'd0, 2'd0, 16'd1);

        // Arithmetic corner cases, back to back through requester 0 (ptr=1, cyclic search finds 0).
        va[0] = 31'h7FFF_FFFF; vb[0] = 31'h7FFF_FFFF; vr[0] = 31'h0000_0000;
        va[1] = 31'h4000_0000; vb[1] = 31'h4000_0000; vr[1] = 31'h0000_0001;
        va[2] = 31'h7FFF_FFFF; vb[2] = 31'h1234_5678; vr[2] = 31'h1234_5678;
        va[3] = 31'h7FFF_FFFF; vb[3] = 31'h0000_0005; vr[3] = 31'h0000_0005;
        for (int i = 0; i < 4; i++) begin
            set_op(0, va[i], vb[i]);
            step();
            chk_rsp($sformatf("arith%0d", i), 1'b1, vr[i], 2'd0, 16'(i + 2));
        end

        // Reset for one cycle with a pending result and op_cnt=5.
        rst_n       = 1'b0;
        req_valid_i = 4'hF;
        #1;
        chk("midrst.ready", 32'(req_ready_o), 32'h0);
        step();
        chk_rsp("midrst", 1'b0, 31'd0, 2'd0, 16'd0);

        // All requesters valid after reset: ids 0,1,2,3,0,1 with no bubbles.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(k, 31'(32'h100 * (k + 1)), 31'(k));
        end
        rr_dat[0] = 31'h100; rr_dat[1] = 31'h201; rr_dat[2] = 31'h302; rr_dat[3] = 31'h403;
        rr_id[0] = 2'd0; rr_id[1] = 2'd1; rr_id[2] = 2'd2;
        rr_id[3] = 2'd3; rr_id[4] = 2'd0; rr_id[5] = 2'd1;
        #1;
        chk("postrst.ready", 32'(req_ready_o), 32'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_rsp($sformatf("rr%0d", i), 1'b1, rr_dat[rr_id[i]], rr_id[i], 16'(i + 1));
        end

        // ptr=2 with requesters 1 and 3: 3 first, then 1.
        req_valid_i = 4'b1010;
        #1;
        chk("skip.ready0", 32'(req_ready_o), 32'b1000);
        step();
        chk_rsp("skip0", 1'b1, 31'h403, 2'd3, 16'd7);
        chk("skip.ready1", 32'(req_ready_o), 32'b0010);
        step();
        chk_rsp("skip1", 1'b1, 31'h201, 2'd1, 16'd8);

        // Backpressure for 3 cycles: no grants, outputs held.
        rsp_ready_i = 1'b0;
        req_valid_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d.ready", i), 32'(req_ready_o), 32'h0);
            step();
            chk_rsp($sformatf("hold%0d", i), 1'b1, 31'h201, 2'd1, 16'd8);
        end

        // Release: drain and fire requester 2 in the same cycle.
        rsp_ready_i = 1'b1;
        #1;
        chk("release.ready", 32'(req_ready_o), 32'b0100);
        step();
        chk_rsp("release", 1'b1, 31'h302, 2'd2, 16'd9);

        // Drain with no new request: valid drops, data and id keep last values.
        req_valid_i = 4'h0;
        #1;
        chk("idle.ready", 32'(req_ready_o), 32'h0);
        step();
        chk_rsp("drain", 1'b0, 31'h302, 2'd2, 16'd9);
        step();
        chk_rsp("idle", 1'b0, 31'h302, 2'd2, 16'd9);

        // Counter wrap: fire requester 0 until op_cnt reaches 0xFFFF, then once more.
        req_valid_i = 4'b0001;
        set_op(0, 31'd1, 31'd2);
        for (int i = 0; i < 65526; i++) begin
            step();
        end
        chk_rsp("cntmax", 1'b1, 31'd3, 2'd0, 16'hFFFF);
        step();
        chk_rsp("cntwrap", 1'b1, 31'd3, 2'd0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m31_add_arbiter.md
M31_ADD_ARBITER -- requirements
Module: m31_add_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of requesters sharing one M31 adder (2..8).
REQ-002 SHALL have derived parameter: ID_W, max(1,$clog2(NUM_REQ)), requester-ID width.
REQ-003 SHALL have one clock; reset is synchronous and active-low; the ports are clk and rst_n.
REQ-004 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port: req_valid_i  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port: req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 SHALL have port: req_a_i  input  NUM_REQ*31  operand A; requester k at bits [31k+30:31k].
REQ-009 SHALL have port: req_b_i  input  NUM_REQ*31  operand B; same packing.
REQ-010 SHALL have port: rsp_valid_o  output  1  result valid.
REQ-011 SHALL have port: rsp_ready_i  input  1  downstream accepts result.
REQ-012 SHALL have port: rsp_data_o  output  31  (A+B) mod (2^31-1), canonical.
REQ-013 SHALL have port: rsp_id_o  output  ID_W  index of the requester that produced rsp_data_o.
REQ-014 SHALL have port: op_cnt_o  output  16  count of accepted operations, wrapping.

Function
REQ-015 SHALL define slot_free = !rsp_valid_o || rsp_ready_i.
REQ-016 SHALL hold a round-robin pointer ptr (ID_W bits, range 0..NUM_REQ-1); the granted requester is the first k with req_valid_i[k]=1, searching cyclically from ptr.
REQ-017 SHALL drive req_ready_o[k]=1 only for the granted k, and only when slot_free=1 and rst_n=1; otherwise all zero.
REQ-018 SHALL allow req_ready_o to depend combinationally on req_valid_i and rsp_ready_i; req_valid_i SHALL NOT be required to depend on ready.
REQ-019 SHALL treat fire = req_valid_i[k] && req_ready_o[k] as acceptance; on fire, next cycle: rsp_valid_o=1, rsp_data_o=sum, rsp_id_o=k, ptr=(k+1) mod NUM_REQ, op_cnt_o incremented by 1.
REQ-020 SHALL compute sum with end-around carry: s=A+B (32 bit); f=s[30:0]+s[31]; result 0 if f==2^31-1, else f.
REQ-021 SHALL accept operands in [0, 2^31-1]; the value 2^31-1 SHALL be treated as 0 (e.g. 0x7FFFFFFF+0x00000005 -> 0x00000005).
REQ-022 SHALL have a latency of exactly 1 cycle from fire to rsp_valid_o, and a throughput of one operation per cycle when rsp_ready_i=1.
REQ-023 SHALL clear rsp_valid_o when rsp_ready_i=1 and no fire occurs in that cycle; simultaneous drain and fire SHALL replace the result with no bubble.
REQ-024 SHALL hold rsp_valid_o, rsp_data_o, rsp_id_o and ptr stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-025 SHALL leave ptr unchanged in cycles with no fire.
REQ-026 SHALL leave rsp_data_o and rsp_id_o at their last values after a drain.
REQ-027 SHALL wrap op_cnt_o from 0xFFFF to 0x0000 on fire.

Reset
REQ-028 SHALL, on a clk edge with rst_n=0, set rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, ptr=0 and op_cnt_o=0.
REQ-029 SHALL discard a pending response when reset is asserted mid-operation; the requester is not re-served.
REQ-030 SHALL force req_ready_o to all zero while rst_n=0, so no fire occurs during reset.

Verification
REQ-031 SHALL cover: requester 0 only, A=0x7FFFFFFE, B=0x00000001, rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_data_o=0, rsp_id_o=0, op_cnt_o=1.
REQ-032 SHALL cover: A=B=0x7FFFFFFF -> 0; A=B=0x40000000 -> 0x00000001; A=0x7FFFFFFF, B=0x12345678 -> 0x12345678.
REQ-033 SHALL cover: all 4 requesters valid continuously, rsp_ready_i=1 -> rsp_id_o sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
REQ-034 SHALL cover: rsp_ready_i=0 with rsp_valid_o=1 for 3 cycles -> req_ready_o=0000 and outputs stable; then rsp_ready_i=1 -> the held result drains and the next grant fires in the same cycle.
REQ-035 SHALL cover: requesters 1 and 3 valid with ptr=2 -> 3 granted first, then 1.
REQ-036 SHALL cover: rst_n=0 for one cycle while rsp_valid_o=1 and op_cnt_o=0x0005 -> all outputs 0; the first post-reset grant with all requesters valid goes to requester 0.
